// File: rtl/axi4_lite_register_file_if.sv
// rtl/axi4_lite_register_file_if.sv - AXI4-Lite signal bundle between the lite fanout and a register bank
interface axi4_if #(
    parameter int A = 32,
    parameter int I = 1
);
    logic [I-1:0]  awid;
    logic [A-1:0]  awaddr;
    logic          awvalid;
    logic          awready;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic          wvalid;
    logic          wready;
    logic [I-1:0]  bid;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [I-1:0]  arid;
    logic [A-1:0]  araddr;
    logic          arvalid;
    logic          arready;
    logic [I-1:0]  rid;
    logic [31:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast;
    logic          rvalid;
    logic          rready;

    modport slave (
        input  awid, awaddr, awvalid, output awready,
        input  wdata, wstrb, wvalid,  output wready,
        output bid, bresp, bvalid,    input  bready,
        input  arid, araddr, arvalid, output arready,
        output rid, rdata, rresp, rlast, rvalid, input rready
    );

    modport master (
        output awid, awaddr, awvalid, input  awready,
        output wdata, wstrb, wvalid,  input  wready,
        input  bid, bresp, bvalid,    output bready,
        output arid, araddr, arvalid, input  arready,
        input  rid, rdata, rresp, rlast, rvalid, output rready
    );
endinterface

// File: rtl/axi4_lite_register_file.sv
// rtl/axi4_lite_register_file.sv - AXI4-Lite slave with N control registers and N read-only status words
module axi4_lite_register_file #(
    parameter int          A   = 32,
    parameter int          N   = 8,
    parameter int          I   = 1,
    parameter logic [31:0] RST = 32'h0
) (
    input  logic                aclk,
    input  logic                areset,
    axi4_if.slave               axi4_s,
    output logic [N-1:0][31:0]  ctrl_q,
    output logic [N-1:0]        ctrl_wr,
    input  logic [N-1:0][31:0]  status_d
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [N-1:0][31:0] ctrl_d;
    logic [N-1:0]       ctrl_wr_q, ctrl_wr_d;

    logic               aw_held_q, aw_held_d;
    logic               w_held_q, w_held_d;
    logic [A-1:0]       awaddr_q, awaddr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         wstrb_q, wstrb_d;
    logic               awready_q, awready_d;
    logic               wready_q, wready_d;
    logic               bvalid_q, bvalid_d;
    logic [1:0]         bresp_q, bresp_d;

    logic               arready_q, arready_d;
    logic               rvalid_q, rvalid_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [1:0]         rresp_q, rresp_d;

    logic [63:0]        widx, ridx;

    // Word index; the byte offset bits never take part in decoding.
    assign widx = 64'(awaddr_q[A-1:2]);
    assign ridx = 64'(axi4_s.araddr[A-1:2]);

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        ctrl_d    = ctrl_q;
        ctrl_wr_d = '0;

        if (bvalid_q && axi4_s.bready)
            bvalid_d = 1'b0;
        if (axi4_s.awvalid && awready_q) begin
            aw_held_d = 1'b1;
            awaddr_d  = axi4_s.awaddr;
        end
        if (axi4_s.wvalid && wready_q) begin
            w_held_d = 1'b1;
            wdata_d  = axi4_s.wdata;
            wstrb_d  = axi4_s.wstrb;
        end

        if (aw_held_q && w_held_q) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = (widx < 64'(N)) ? RESP_OKAY : RESP_SLVERR;
            for (int k = 0; k < N; k++) begin
                if (widx == 64'(k)) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wstrb_q[b])
                            ctrl_d[k][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                    ctrl_wr_d[k] = 1'b1;
                end
            end
        end

        // Readies are registered images of the next-cycle acceptance condition.
        awready_d = !aw_held_d && !bvalid_d;
        wready_d  = !w_held_d && !bvalid_d;
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;

        if (rvalid_q && axi4_s.rready)
            rvalid_d = 1'b0;

        if (axi4_s.arvalid && arready_q) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_OKAY;
            if (ridx < 64'(N)) begin
                for (int k = 0; k < N; k++) begin
                    if (ridx == 64'(k))
                        rdata_d = ctrl_q[k];
                end
            end else if (ridx < 64'(2 * N)) begin
                for (int k = 0; k < N; k++) begin
                    if (ridx == 64'(N + k))
                        rdata_d = status_d[k];
                end
            end else begin
                rresp_d = RESP_SLVERR;
            end
        end

        arready_d = !rvalid_d;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            ctrl_q    <= {N{RST}};
            ctrl_wr_q <= '0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            ctrl_q    <= ctrl_d;
            ctrl_wr_q <= ctrl_wr_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    assign ctrl_wr        = ctrl_wr_q;
    assign axi4_s.awready = awready_q;
    assign axi4_s.wready  = wready_q;
    assign axi4_s.bvalid  = bvalid_q;
    assign axi4_s.bresp   = bresp_q;
    assign axi4_s.bid     = '0;
    assign axi4_s.arready = arready_q;
    assign axi4_s.rvalid  = rvalid_q;
    assign axi4_s.rdata   = rdata_q;
    assign axi4_s.rresp   = rresp_q;
    assign axi4_s.rid     = '0;
    assign axi4_s.rlast   = 1'b1;

    logic unused_ok;
    assign unused_ok = ^{axi4_s.awid, axi4_s.arid, awaddr_q[1:0], axi4_s.araddr[1:0]};
endmodule

// File: tb/tb_axi4_lite_register_file.sv
// tb/tb_axi4_lite_register_file.sv - directed vector bench for axi4_lite_register_file
module tb_axi4_lite_register_file;
    localparam int N = 8;

    logic aclk = 1'b0;
    logic areset;
    always #5 aclk = ~aclk;

    axi4_if #(.A(32), .I(1)) bus ();
    logic [N-1:0][31:0] ctrl_q;
    logic [N-1:0]       ctrl_wr;
    logic [N-1:0][31:0] status_d;

    axi4_lite_register_file #(.A(32), .N(N), .I(1), .RST(32'h0)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .axi4_s   (bus),
        .ctrl_q   (ctrl_q),
        .ctrl_wr  (ctrl_wr),
        .status_d (status_d)
    );

    int checks   = 0;
    int failures = 0;
    logic [31:0] mdl [N];

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] exp;
        logic [7:0]  exp_wr;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_ctrl(input string tag);
        for (int k = 0; k < N; k++)
            check($sformatf("%s ctrl_q[%0d]", tag, k), ctrl_q[k], mdl[k]);
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output int cyc,
                            output logic [7:0] wr_mask, output int wr_cycles);
        logic aw_acc, w_acc;
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = strb;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        cyc = 0;
        wr_mask = '0;
        wr_cycles = 0;
        while (!bus.bvalid && cyc < 20) begin
            aw_acc = bus.awvalid && bus.awready;
            w_acc  = bus.wvalid && bus.wready;
            tick();
            cyc++;
            if (aw_acc) bus.awvalid = 1'b0;
            if (w_acc)  bus.wvalid  = 1'b0;
        end
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        resp = bus.bresp;
        for (int j = 0; j < 3; j++) begin
            if (ctrl_wr != '0) begin
                wr_mask |= ctrl_wr;
                wr_cycles++;
            end
            tick();
        end
    endtask

    task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp, output int cyc);
        logic ar_acc;
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        cyc = 0;
        while (!bus.rvalid && cyc < 20) begin
            ar_acc = bus.arvalid && bus.arready;
            tick();
            cyc++;
            if (ar_acc) bus.arvalid = 1'b0;
        end
        bus.arvalid = 1'b0;
        data = bus.rdata;
        resp = bus.rresp;
        tick();
    endtask

    function automatic vec_t mk(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb, input logic [1:0] resp,
                                input logic [31:0] exp, input logic [7:0] exp_wr);
        vec_t v;
        v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
        v.resp = resp; v.exp = exp; v.exp_wr = exp_wr;
        return v;
    endfunction

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [7:0]  wrm;
        int          cyc, wrc;
        logic [31:0] a;

        vecs[0]  = mk(1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 2'b00, 32'hDEADBEEF, 8'h02);
        vecs[1]  = mk(1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF, 8'h00);
        vecs[2]  = mk(1'b1, 32'h00, 32'h12345678, 4'h5, 2'b00, 32'h00340078, 8'h01);
        vecs[3]  = mk(1'b1, 32'h1C, 32'hAABBCCDD, 4'h0, 2'b00, 32'h00000000, 8'h80);
        vecs[4]  = mk(1'b1, 32'h1E, 32'h11223344, 4'hC, 2'b00, 32'h11220000, 8'h80);
        vecs[5]  = mk(1'b0, 32'h24, 32'h0,        4'h0, 2'b00, 32'h00001234, 8'h00);
        vecs[6]  = mk(1'b0, 32'h40, 32'h0,        4'h0, 2'b10, 32'h00000000, 8'h00);
        vecs[7]  = mk(1'b1, 32'h24, 32'h99999999, 4'hF, 2'b10, 32'h00000000, 8'h00);
        vecs[8]  = mk(1'b1, 32'h3C, 32'h77777777, 4'hF, 2'b10, 32'h00000000, 8'h00);
        vecs[9]  = mk(1'b0, 32'h3C, 32'h0,        4'h0, 2'b00, 32'hA0000007, 8'h00);
        vecs[10] = mk(1'b0, 32'h20, 32'h0,        4'h0, 2'b00, 32'hA0000000, 8'h00);
        vecs[11] = mk(1'b0, 32'h1C, 32'h0,        4'h0, 2'b00, 32'h11220000, 8'h00);
        vecs[12] = mk(1'b1, 32'h40, 32'h55555555, 4'hF, 2'b10, 32'h00000000, 8'h00);
        vecs[13] = mk(1'b0, 32'h00, 32'h0,        4'h0, 2'b00, 32'h00340078, 8'h00);

        for (int k = 0; k < N; k++) begin
            status_d[k] = 32'hA0000000 + 32'(k);
            mdl[k] = 32'h0;
        end
        status_d[1] = 32'h00001234;

        bus.awid = '0; bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
        bus.bready = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arvalid = 1'b0;
        bus.rready = 1'b1;
        areset = 1'b1;

        repeat (3) @(posedge aclk);
        #1;
        check_ctrl("reset");
        check("reset bvalid", 32'(bus.bvalid), 32'd0);
        check("reset rvalid", 32'(bus.rvalid), 32'd0);
        check("reset awready", 32'(bus.awready), 32'd0);
        check("reset arready", 32'(bus.arready), 32'd0);
        check("reset ctrl_wr", 32'(ctrl_wr), 32'd0);
        areset = 1'b0;
        tick();
        check("release awready", 32'(bus.awready), 32'd1);
        check("release wready", 32'(bus.wready), 32'd1);
        check("release arready", 32'(bus.arready), 32'd1);

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp, cyc, wrm, wrc);
                check($sformatf("vec%0d bresp", i), 32'(resp), 32'(vecs[i].resp));
                check($sformatf("vec%0d bvalid latency", i), 32'(cyc), 32'd2);
                check($sformatf("vec%0d ctrl_wr mask", i), 32'(wrm), 32'(vecs[i].exp_wr));
                check($sformatf("vec%0d ctrl_wr cycles", i), 32'(wrc),
                      (vecs[i].exp_wr != 8'h0) ? 32'd1 : 32'd0);
                if (vecs[i].resp == 2'b00) begin
                    a = vecs[i].addr;
                    mdl[a[4:2]] = vecs[i].exp;
                end
                check_ctrl($sformatf("vec%0d", i));
            end else begin
                do_read(vecs[i].addr, rdata, resp, cyc);
                check($sformatf("vec%0d rresp", i), 32'(resp), 32'(vecs[i].resp));
                check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp);
                check($sformatf("vec%0d rvalid latency", i), 32'(cyc), 32'd1);
            end
        end

        // W leads AW by three cycles
        bus.wdata = 32'h000000AA; bus.wstrb = 4'h1; bus.wvalid = 1'b1;
        check("wfirst wready before", 32'(bus.wready), 32'd1);
        tick();
        bus.wvalid = 1'b0;
        check("wfirst wready held1", 32'(bus.wready), 32'd0);
        tick();
        check("wfirst wready held2", 32'(bus.wready), 32'd0);
        check("wfirst awready", 32'(bus.awready), 32'd1);
        tick();
        check("wfirst wready held3", 32'(bus.wready), 32'd0);
        bus.awaddr = 32'h04; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        check("wfirst wready held4", 32'(bus.wready), 32'd0);
        check("wfirst bvalid early", 32'(bus.bvalid), 32'd0);
        tick();
        check("wfirst bvalid", 32'(bus.bvalid), 32'd1);
        check("wfirst bresp", 32'(bus.bresp), 32'd0);
        check("wfirst wready during b", 32'(bus.wready), 32'd0);
        mdl[1] = 32'hDEADBEAA;
        check("wfirst ctrl_q[1]", ctrl_q[1], mdl[1]);
        tick();
        check("wfirst bvalid cleared", 32'(bus.bvalid), 32'd0);
        check("wfirst wready after b", 32'(bus.wready), 32'd1);
        check("wfirst awready after b", 32'(bus.awready), 32'd1);

        // B stalled for five cycles while a read completes
        bus.bready = 1'b0;
        do_write(32'h08, 32'h00000055, 4'hF, resp, cyc, wrm, wrc);
        check("bstall bresp", 32'(resp), 32'd0);
        check("bstall latency", 32'(cyc), 32'd2);
        check("bstall ctrl_wr mask", 32'(wrm), 32'h04);
        check("bstall ctrl_wr cycles", 32'(wrc), 32'd1);
        mdl[2] = 32'h00000055;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bstall%0d bvalid", i), 32'(bus.bvalid), 32'd1);
            check($sformatf("bstall%0d awready", i), 32'(bus.awready), 32'd0);
            check($sformatf("bstall%0d wready", i), 32'(bus.wready), 32'd0);
            if (i == 0) begin
                check("bstall arready", 32'(bus.arready), 32'd1);
                bus.araddr = 32'h08; bus.arvalid = 1'b1;
            end
            if (i == 1) begin
                bus.arvalid = 1'b0;
                check("bstall rvalid", 32'(bus.rvalid), 32'd1);
                check("bstall rdata", bus.rdata, 32'h00000055);
                check("bstall rresp", 32'(bus.rresp), 32'd0);
            end
            tick();
        end
        bus.bready = 1'b1;
        tick();
        check("bstall bvalid cleared", 32'(bus.bvalid), 32'd0);
        check("bstall awready back", 32'(bus.awready), 32'd1);
        check_ctrl("bstall");

        // Reset with an AW held and a read response pending
        bus.awaddr = 32'h10; bus.awvalid = 1'b1;
        bus.araddr = 32'h04; bus.arvalid = 1'b1;
        bus.rready = 1'b0;
        tick();
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        check("midrst rvalid before", 32'(bus.rvalid), 32'd1);
        areset = 1'b1;
        tick();
        tick();
        areset = 1'b0;
        check("midrst bvalid", 32'(bus.bvalid), 32'd0);
        check("midrst rvalid", 32'(bus.rvalid), 32'd0);
        for (int k = 0; k < N; k++) mdl[k] = 32'h0;
        check_ctrl("midrst");
        bus.rready = 1'b1;
        tick();
        check("midrst awready", 32'(bus.awready), 32'd1);
        check("midrst bvalid idle", 32'(bus.bvalid), 32'd0);
        do_write(32'h0C, 32'hCAFEF00D, 4'hF, resp, cyc, wrm, wrc);
        check("postrst bresp", 32'(resp), 32'd0);
        check("postrst latency", 32'(cyc), 32'd2);
        check("postrst ctrl_wr mask", 32'(wrm), 32'h08);
        mdl[3] = 32'hCAFEF00D;
        check_ctrl("postrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
